ctr_stream_ctrl: RTL
====================

# ctr_stream_ctrl

Multi-block CTR-mode sequencer that sits directly upstream of the inverse-cipher core and replaces the single-shot counter-block/XOR path. It holds the 64-bit IV and a 64-bit block counter, and accepts ciphertext blocks over a valid/ready stream. For each block it issues one keystream request to the core, XORs the returned keystream with the buffered ciphertext, and presents plaintext on an output valid/ready stream. The counter advances once per delivered block.

## Interface
- Nb, 4, state columns; block width is 32*Nb = 128
- CTR_W, 64, counter width; IV width is 32*Nb-CTR_W = 64

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- iv  in  64  IV; sampled when load=1
- load  in  1  latch iv, clear counter, abort any block in flight
- ct_valid  in  1  ciphertext block offered
- ct_ready  out  1  block accepted when ct_valid & ct_ready
- ct_data  in  128  ciphertext block
- pt_valid  out  1  plaintext block valid
- pt_ready  in  1  downstream accepts when pt_valid & pt_ready
- pt_data  out  128  plaintext block
- core_start  out  1  one-cycle request to the cipher core
- core_block  out  128  counter block {iv_q, ctr_q}, stable from core_start until core_ready
- core_ready  in  1  one-cycle pulse; core_out valid in that cycle
- core_out  in  128  keystream block
- blk_cnt  out  64  current counter value ctr_q

## Operation
- FSM states: NOIV, WAIT_CT, START, BUSY, OUT, DRAIN.
- Reset: state is NOIV. iv_q, ctr_q, ct_q and pt_data are 0. ct_ready, pt_valid and core_start are 0.
- NOIV: ct_ready=0. load → WAIT_CT.
- WAIT_CT: ct_ready=1. On a ct handshake, ct_data is captured in ct_q and the FSM moves to START.
- START: core_start=1 for exactly this cycle, then BUSY.
- BUSY: wait for core_ready. On core_ready, pt_data ← core_out ^ ct_q, pt_valid ← 1, and the FSM moves to OUT.
- OUT: pt_valid and pt_data are held stable until pt_ready. On the pt handshake, ctr_q ← ctr_q+1 (mod 2^64, 0xFFFF_FFFF_FFFF_FFFF wraps to 0) and the FSM returns to WAIT_CT.
- load in any state: iv_q ← iv, ctr_q ← 0, pt_valid ← 0, and any captured ct is discarded.
  - From START or BUSY: next state is DRAIN. The core is already committed.
  - From any other state: next state is WAIT_CT.
- DRAIN: ct_ready=0. The next core_ready is consumed and its data discarded, then WAIT_CT. A load in DRAIN updates iv_q/ctr_q and stays in DRAIN.
- core_ready outside BUSY/DRAIN is ignored.
- load has priority over a same-cycle ct or pt handshake. That handshake does not complete: ct_ready and pt_valid are forced to 0 in a cycle where load=1.
- Single-buffered: a new ct cannot be accepted until the current plaintext is taken. No ct/pt overlap.

## Timing
- ct handshake at cycle T → core_start at T+1. Core latency L runs from core_start to core_ready, so core_ready is at T+1+L.
- pt_valid rises at T+2+L (registered).
- Peak throughput: one block per L+3 cycles when pt_ready is held high.
- core_block changes only in WAIT_CT/NOIV. It is never modified while the core is working.
- blk_cnt reflects ctr_q. It is updated the cycle after the pt handshake.

## Structure
- Shared package aes_ctr_pkg holds:
  - localparams BLK_W=128, CTR_W=64, IV_W=64
  - typedef enum logic [2:0] state_t {NOIV, WAIT_CT, START, BUSY, OUT, DRAIN}
  - typedef logic [127:0] block_t
- Natural sub-module: ctr_block_gen. It holds iv_q/ctr_q with load/incr controls, implements the wrapping increment, and drives core_block.
- The XOR and FSM stay in the top.

## Test plan
- Reset, then load iv=64'h0001020304050607; send ct=128'h0. Required: core_block=128'h0001020304050607_0000000000000000; pt_data=core_out (stub core returns fixed data after L=12); pt_valid at T+14.
- Three back-to-back ct blocks with pt_ready=1 and stub keystream=counter block. Required: core_block low words 0, 1, 2; blk_cnt=3 at the end; pt = ct ^ core_block for each.
- Backpressure: hold pt_ready=0 for 20 cycles in OUT. Required: pt_valid/pt_data stable, ct_ready=0, no second core_start.
- Wrap: force ctr_q to 64'hFFFF_FFFF_FFFF_FFFF via load plus repeated blocks in the model. After one block, required: ctr_q=0 and the next core_block low word=0.
- load pulsed in BUSY with iv=64'hA5A5_A5A5_A5A5_A5A5. Required: state DRAIN; the late core_ready produces no pt_valid; the next ct uses core_block={A5..A5, 64'h0}.
- rst asserted mid-OUT. Required: the next cycle has pt_valid=0, ct_ready=0 and state NOIV; ct is refused until load.

Source files
------------

// File: rtl/aes_ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctr_pkg
//  Description : Shared widths, types and helpers for the CTR-mode stream
//                sequencer in front of the inverse-cipher core.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_ctr_pkg;

    localparam int BLK_W = 128;
    localparam int CTR_W = 64;
    localparam int IV_W  = BLK_W - CTR_W;

    typedef enum logic [2:0] {
        NOIV    = 3'd0,
        WAIT_CT = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        OUT     = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    typedef logic [BLK_W-1:0] block_t;
    typedef logic [CTR_W-1:0] ctr_t;
    typedef logic [IV_W-1:0]  iv_t;

    // Counter block as presented to the cipher core: IV in the upper half,
    // block counter in the lower half.
    function automatic block_t make_ctr_block(input iv_t f_iv, input ctr_t f_ctr);
        return {f_iv, f_ctr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctr_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_stream_ctrl_if
//  Description : Ciphertext-in / plaintext-out streams plus the request and
//                response bus toward the cipher core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ctr_stream_ctrl_if;
    import aes_ctr_pkg::*;

    // ciphertext input stream
    logic   ct_valid;
    logic   ct_ready;
    block_t ct_data;

    // plaintext output stream
    logic   pt_valid;
    logic   pt_ready;
    block_t pt_data;

    // cipher core request / response
    logic   core_start;
    block_t core_block;
    logic   core_ready;
    block_t core_out;

    // Sequencer side
    modport master (
        input  ct_valid, ct_data, pt_ready, core_ready, core_out,
        output ct_ready, pt_valid, pt_data, core_start, core_block
    );

    // Environment side: upstream source, downstream sink and cipher core
    modport slave (
        output ct_valid, ct_data, pt_ready, core_ready, core_out,
        input  ct_ready, pt_valid, pt_data, core_start, core_block
    );

endinterface
`default_nettype wire

// File: rtl/ctr_stream_ctrl_block_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_block_gen
//  Description : Holds the IV and the 64-bit block counter, implements the
//                wrapping increment and drives the counter block seen by the
//                cipher core.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctr_block_gen
    import aes_ctr_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,       // latch iv, clear counter
    input  iv_t    iv,
    input  logic   incr,       // advance counter by one (wraps at 2^64)
    input  logic   track,      // core idle: counter block may follow iv/ctr
    output block_t core_block,
    output ctr_t   ctr_q
);

    iv_t    r_iv_q;
    ctr_t   r_ctr_q;
    block_t r_core_block;

    // Next counter value; load wins, the add wraps naturally at CTR_W bits.
    wire [CTR_W-1:0] w_ctr_nxt;
    assign w_ctr_nxt = load ? '0 : (incr ? (r_ctr_q + ctr_t'(1)) : r_ctr_q);

    // IV and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv_q  <= '0;
            r_ctr_q <= '0;
        end else begin
            if (load) begin
                r_iv_q <= iv;
            end
            r_ctr_q <= w_ctr_nxt;
        end
    end

    // Counter block is frozen while the core owns it; it only follows the
    // IV/counter while the sequencer is idle (no block in flight).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_block <= '0;
        end else if (track) begin
            r_core_block <= make_ctr_block(r_iv_q, r_ctr_q);
        end
    end

    assign core_block = r_core_block;
    assign ctr_q      = r_ctr_q;

endmodule
`default_nettype wire

// File: rtl/ctr_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_stream_ctrl
//  Description : Multi-block CTR-mode sequencer. Accepts ciphertext blocks,
//                requests one keystream block per ciphertext from the cipher
//                core, XORs and presents plaintext. Single-buffered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctr_stream_ctrl
    import aes_ctr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  iv_t               iv,
    input  logic              load,
    output ctr_t              blk_cnt,
    ctr_stream_ctrl_if.master bus
);

    localparam logic [2:0] c_st_noiv    = NOIV;
    localparam logic [2:0] c_st_wait_ct = WAIT_CT;
    localparam logic [2:0] c_st_start   = START;
    localparam logic [2:0] c_st_busy    = BUSY;
    localparam logic [2:0] c_st_out     = OUT;
    localparam logic [2:0] c_st_drain   = DRAIN;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    block_t     r_ct_q;
    block_t     r_pt_data;
    logic       r_pt_valid;

    logic       w_ct_ready;
    logic       w_ct_fire;
    logic       w_pt_fire;
    logic       w_ks_take;
    logic       w_track;

    // load blocks both handshakes in the cycle it is asserted
    assign w_ct_ready = (r_state == c_st_wait_ct) && !load;
    assign w_ct_fire  = w_ct_ready && bus.ct_valid;
    assign w_pt_fire  = r_pt_valid && bus.pt_ready && !load;
    assign w_ks_take  = (r_state == c_st_busy) && bus.core_ready && !load;
    assign w_track    = (r_state == c_st_noiv) || (r_state == c_st_wait_ct);

    // Next-state selection; load overrides normal progress
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            case (r_state)
                // request already issued: its response must still be swallowed
                c_st_start: w_state_nxt = c_st_drain;
                // a response arriving in the load cycle already settles the core
                c_st_busy,
                c_st_drain: w_state_nxt = bus.core_ready ? c_st_wait_ct : c_st_drain;
                default:    w_state_nxt = c_st_wait_ct;
            endcase
        end else begin
            case (r_state)
                c_st_noiv:    w_state_nxt = c_st_noiv;
                c_st_wait_ct: w_state_nxt = w_ct_fire ? c_st_start : c_st_wait_ct;
                c_st_start:   w_state_nxt = c_st_busy;
                c_st_busy:    w_state_nxt = bus.core_ready ? c_st_out : c_st_busy;
                c_st_out:     w_state_nxt = bus.pt_ready ? c_st_wait_ct : c_st_out;
                c_st_drain:   w_state_nxt = bus.core_ready ? c_st_wait_ct : c_st_drain;
                default:      w_state_nxt = c_st_noiv;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_noiv;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ciphertext buffer; a load discards whatever was captured
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_ct_q <= '0;
        end else if (w_ct_fire) begin
            r_ct_q <= bus.ct_data;
        end
    end

    // Plaintext output register, held until the downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
        end else if (load) begin
            r_pt_valid <= 1'b0;
        end else if (w_ks_take) begin
            r_pt_valid <= 1'b1;
            r_pt_data  <= bus.core_out ^ r_ct_q;
        end else if (w_pt_fire) begin
            r_pt_valid <= 1'b0;
        end
    end

    ctr_block_gen u_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .iv         (iv),
        .incr       (w_pt_fire),
        .track      (w_track),
        .core_block (bus.core_block),
        .ctr_q      (blk_cnt)
    );

    assign bus.ct_ready   = w_ct_ready;
    assign bus.pt_valid   = r_pt_valid && !load;
    assign bus.pt_data    = r_pt_data;
    assign bus.core_start = (r_state == c_st_start);

endmodule
`default_nettype wire
